// File: rtl/uart_word_rx.sv
// -----------------------------------------------------------------------------
// uart_word_rx
//
// Receive side of the 32-bit word link. Recovers 8N1 UART bytes from an
// asynchronous serial line. Each bit is decided by a 3-sample majority vote
// taken around mid-bit. Four consecutive bytes, LSB byte first, are assembled
// into one 32-bit word. The completed word is presented with a one-cycle valid
// strobe.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 8)
//   TIMEOUT_BITS  idle bit-times allowed between the bytes of one word before
//                 the partial word is abandoned
//
// Ports
//   clk                in   system clock
//   rst                in   asynchronous, active-high reset
//   rx_serial          in   asynchronous serial input, idle high
//   o_sys_data         out  last completed word; byte0 in [7:0], byte3 in [31:24]
//   sys_rx_data_valid  out  one-cycle pulse: o_sys_data updated this cycle
//   frame_error        out  one-cycle pulse: stop bit sampled low
//   word_timeout       out  one-cycle pulse: partial word abandoned
//   rx_busy            out  byte in flight or word partially assembled
// -----------------------------------------------------------------------------
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_serial,
  output logic [31:0] o_sys_data,
  output logic        sys_rx_data_valid,
  output logic        frame_error,
  output logic        word_timeout,
  output logic        rx_busy
);

  localparam int BW         = $clog2(CLKS_PER_BIT);
  localparam int HALF       = CLKS_PER_BIT / 2;
  localparam int IDLE_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IW         = $clog2(IDLE_LIMIT + 1);

  localparam logic [BW-1:0] CNT_LO    = BW'(HALF - 1);
  localparam logic [BW-1:0] CNT_MID   = BW'(HALF);
  localparam logic [BW-1:0] CNT_HI    = BW'(HALF + 1);
  localparam logic [BW-1:0] CNT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      sync;
  logic            rxs;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            s_lo, s_mid;
  logic            armed;
  logic [1:0]      byte_cnt;
  logic [23:0]     lanes;
  logic [IW-1:0]   idle_cnt;

  logic at_lo, at_mid, at_hi, vote;
  logic start_go, bit_shift, accept, ferr, tmo;

  // Two-flop synchronizer; resets to the idle (high) line level so reset
  // release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    else     sync <= {sync[0], rx_serial};
  end

  assign rxs    = sync[1];
  assign at_lo  = (baud_cnt == CNT_LO);
  assign at_mid = (baud_cnt == CNT_MID);
  assign at_hi  = (baud_cnt == CNT_HI);
  // Third sample is the live synchronizer output at H+1.
  assign vote   = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);

  assign rx_busy = (state != IDLE) || (byte_cnt != 2'd0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    start_go  = 1'b0;
    bit_shift = 1'b0;
    accept    = 1'b0;
    ferr      = 1'b0;
    // Timeout is independent of the FSM: a start edge in the same cycle still
    // proceeds, and that byte becomes byte 0 of a fresh word.
    tmo       = (state == IDLE) && (byte_cnt != 2'd0) && (idle_cnt == IDLE_LAST);
    unique case (state)
      IDLE: begin
        if (!rxs && armed) begin
          state_nxt = START;
          start_go  = 1'b1;
        end
      end
      START: begin
        if (at_hi) state_nxt = vote ? IDLE : DATA;
      end
      DATA: begin
        if (at_hi) begin
          bit_shift = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE at mid stop bit lets the next start bit be caught
        // even when frames are sent back to back.
        if (at_hi) begin
          accept    = vote;
          ferr      = ~vote;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing and sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      s_lo     <= 1'b1;
      s_mid    <= 1'b1;
      armed    <= 1'b1;
    end else begin
      if (start_go)
        baud_cnt <= '0;
      else if (state != IDLE)
        baud_cnt <= (baud_cnt == CNT_LAST) ? '0 : baud_cnt + 1'b1;

      if (at_lo)  s_lo  <= rxs;
      if (at_mid) s_mid <= rxs;

      if (state == START && at_hi) bit_idx <= '0;
      else if (bit_shift)          bit_idx <= bit_idx + 1'b1;

      if (bit_shift) shreg <= {vote, shreg[7:1]};

      // After a frame error the line must return high before another start
      // is accepted, so a held-low break produces a single error.
      if (ferr)     armed <= 1'b0;
      else if (rxs) armed <= 1'b1;
    end
  end

  // Word assembly, inter-byte timeout and output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the lane storage is reset along with the control state so that
      // no byte of an interrupted word can leak into a later one.
      lanes             <= '0;
      byte_cnt          <= '0;
      idle_cnt          <= '0;
      o_sys_data        <= '0;
      sys_rx_data_valid <= 1'b0;
      frame_error       <= 1'b0;
      word_timeout      <= 1'b0;
    end else begin
      sys_rx_data_valid <= accept && (byte_cnt == 2'd3);
      frame_error       <= ferr;
      word_timeout      <= tmo;

      if (state_nxt != IDLE || byte_cnt == 2'd0 || tmo)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      if (tmo || ferr) begin
        byte_cnt <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 1'b1;
        unique case (byte_cnt)
          2'd0: lanes[7:0]   <= shreg;
          2'd1: lanes[15:8]  <= shreg;
          2'd2: lanes[23:16] <= shreg;
          2'd3: o_sys_data   <= {shreg, lanes};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_word_rx
//
// Directed bench for uart_word_rx with CLKS_PER_BIT=16, TIMEOUT_BITS=20.
// Serial stimulus is driven on the falling clock edge; output pulses are
// counted on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_word_rx;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_serial;
  logic [31:0] o_sys_data;
  logic        sys_rx_data_valid;
  logic        frame_error;
  logic        word_timeout;
  logic        rx_busy;

  int checks = 0;
  int errors = 0;

  int n_valid = 0;
  int n_ferr  = 0;
  int n_tmo   = 0;
  int n_multi = 0;

  int v0, f0, t0;
  logic [9:0] pf;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_serial         (rx_serial),
    .o_sys_data        (o_sys_data),
    .sys_rx_data_valid (sys_rx_data_valid),
    .frame_error       (frame_error),
    .word_timeout      (word_timeout),
    .rx_busy           (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (sys_rx_data_valid) n_valid++;
      if (frame_error)       n_ferr++;
      if (word_timeout)      n_tmo++;
      if (32'(sys_rx_data_valid) + 32'(frame_error) + 32'(word_timeout) > 1) n_multi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One 8N1 frame; glitch_bit >= 0 inverts one clock at sample H of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        rx_serial = f[i] ^ ((i == glitch_bit + 1) && (c == 9));
        @(negedge clk);
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_frame(w[8*k +: 8], 1'b1, -1);
  endtask

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",  o_sys_data,        32'h0);
    check("reset_valid", sys_rx_data_valid, 32'h0);
    check("reset_ferr",  frame_error,       32'h0);
    check("reset_tmo",   word_timeout,      32'h0);
    check("reset_busy",  rx_busy,           32'h0);
    rst = 1'b0;
    idle_bits(2);

    // 1: back-to-back word
    v0 = n_valid;
    send_word(32'h44332211);
    check("t1_data",  o_sys_data,   32'h44332211);
    check("t1_valid", n_valid - v0, 32'd1);
    check("t1_ferr",  n_ferr,       32'd0);
    check("t1_tmo",   n_tmo,        32'd0);
    check("t1_busy",  rx_busy,      32'h0);
    idle_bits(2);

    // 2: short low pulse is a false start
    v0 = n_valid;
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(2);
    check("t2_novalid", n_valid - v0, 32'd0);
    check("t2_noferr",  n_ferr,       32'd0);
    check("t2_busy",    rx_busy,      32'h0);
    send_word(32'hCAFEF00D);
    check("t2_data",  o_sys_data,   32'hCAFEF00D);
    check("t2_valid", n_valid - v0, 32'd1);
    idle_bits(2);

    // 3: glitch on data bit 3 of 0xA5 is voted out
    send_frame(8'hA5, 1'b1, 3);
    send_frame(8'h5A, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    check("t3_data", o_sys_data, 32'h3CC35AA5);
    idle_bits(2);

    // 4: bad stop bit discards the partial word
    v0 = n_valid;
    send_frame(8'hDE, 1'b1, -1);
    send_frame(8'hAD, 1'b0, -1);
    idle_bits(2);
    check("t4_ferr",    n_ferr,       32'd1);
    check("t4_novalid", n_valid - v0, 32'd0);
    check("t4_hold",    o_sys_data,   32'h3CC35AA5);
    check("t4_busy",    rx_busy,      32'h0);
    send_word(32'h04030201);
    check("t4_data", o_sys_data, 32'h04030201);
    idle_bits(2);

    // 5: inter-byte timeout
    v0 = n_valid;
    send_frame(8'h12, 1'b1, -1);
    send_frame(8'h34, 1'b1, -1);
    idle_bits(1);
    check("t5_busy_partial", rx_busy, 32'h1);
    check("t5_tmo_early",    n_tmo,   32'd0);
    idle_bits(20);
    check("t5_tmo",     n_tmo,        32'd1);
    check("t5_busy",    rx_busy,      32'h0);
    check("t5_novalid", n_valid - v0, 32'd0);
    send_word(32'hDEADBEEF);
    check("t5_data",  o_sys_data,   32'hDEADBEEF);
    check("t5_valid", n_valid - v0, 32'd1);
    idle_bits(2);

    // 6: reset during data bit 4 of byte 2, then a held-low break
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'h66, 1'b1, -1);
    pf = {1'b1, 8'h77, 1'b0};
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < CPB; c++) begin
        rx_serial = pf[i];
        @(negedge clk);
      end
    end
    rx_serial = pf[5];
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_data",  o_sys_data,        32'h0);
    check("t6_rst_valid", sys_rx_data_valid, 32'h0);
    check("t6_rst_ferr",  frame_error,       32'h0);
    check("t6_rst_tmo",   word_timeout,      32'h0);
    check("t6_rst_busy",  rx_busy,           32'h0);
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    v0 = n_valid;
    f0 = n_ferr;
    t0 = n_tmo;
    send_word(32'h13579BDF);
    check("t6_data",  o_sys_data,   32'h13579BDF);
    check("t6_valid", n_valid - v0, 32'd1);
    idle_bits(2);
    rx_serial = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    idle_bits(2);
    check("t6_break_ferr",  n_ferr - f0,  32'd1);
    check("t6_break_valid", n_valid - v0, 32'd1);
    check("t6_break_tmo",   n_tmo - t0,   32'd0);
    check("t6_break_hold",  o_sys_data,   32'h13579BDF);

    check("one_pulse_per_cycle", n_multi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
